// File: rtl/mux4_pkg.sv
// mux4_pkg: shared definitions for the four-to-one stream multiplexer.
//   chan_t  : 2-bit channel index, MSB drives s0, LSB drives s1
//   NCH     : number of input channels
//   CH0..CH3: channel index constants (same encoding as the 1-to-4 demux select)
//   W_DEF   : default data width
package mux4_pkg;

    typedef logic [1:0] chan_t;

    localparam int    NCH   = 4;
    localparam int    W_DEF = 8;

    localparam chan_t CH0 = 2'd0;
    localparam chan_t CH1 = 2'd1;
    localparam chan_t CH2 = 2'd2;
    localparam chan_t CH3 = 2'd3;

    // One-hot encoding of a channel index
    function automatic logic [3:0] chan_onehot(input chan_t c);
        logic [3:0] oh;
        oh = 4'b0001 << c;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: four-way arbiter for mux4_stream.
//   req_i : request vector, bit k = channel k valid
//   ptr_i : index of the last granted channel (search starts at ptr_i+1)
//   en_i  : arbitration enable; low forces no grant
//   gnt_o : one-hot grant (all zero when no grant)
//   idx_o : granted channel index (CH0 when no grant)
// Build option MUX4_FIXED_PRIO_EN: fixed priority ch0 > ch1 > ch2 > ch3,
// ptr_i is then ignored.
module rr_arb4
    import mux4_pkg::*;
(
    input  logic [3:0] req_i,
    input  chan_t      ptr_i,
    input  logic       en_i,
    output logic [3:0] gnt_o,
    output chan_t      idx_o
);

    logic  found_s;
    chan_t idx_s;
    chan_t cand_s;

`ifdef MUX4_FIXED_PRIO_EN
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr_i;

    // Fixed priority: lowest-index valid channel wins
    always_comb begin
        found_s = 1'b0;
        idx_s   = CH0;
        cand_s  = CH0;
        if (en_i) begin
            for (int k = 0; k < NCH; k++) begin
                cand_s = chan_t'(k);
                if (!found_s && req_i[cand_s]) begin
                    found_s = 1'b1;
                    idx_s   = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end
`else
    // Round-robin: scan ptr+1, ptr+2, ... wrapping modulo 4
    always_comb begin
        found_s = 1'b0;
        idx_s   = CH0;
        cand_s  = CH0;
        if (en_i) begin
            for (int k = 1; k <= NCH; k++) begin
                cand_s = ptr_i + chan_t'(k);
                if (!found_s && req_i[cand_s]) begin
                    found_s = 1'b1;
                    idx_s   = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end
`endif

    assign gnt_o = found_s ? chan_onehot(idx_s) : 4'b0000;
    assign idx_o = idx_s;

endmodule

// File: rtl/mux4_stream.sv
// mux4_stream: merges four valid/ready channels onto one registered output,
// tagging each word with its source channel.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   en            : grant enable (a held output word still drains when low)
//   i0..i3, v0..v3: channel data / valid
//   r0..r3        : channel ready (grant), combinational
//   y, yv, yr     : merged data, valid (registered) and downstream ready
//   s0, s1        : source channel of y, registered, {s0,s1} = index
// Build option MUX4_FIXED_PRIO_EN selects fixed priority instead of
// round-robin; ports and latency are unchanged.
module mux4_stream
    import mux4_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic         v0,
    input  logic         v1,
    input  logic         v2,
    input  logic         v3,
    output logic         r0,
    output logic         r1,
    output logic         r2,
    output logic         r3,
    output logic [W-1:0] y,
    output logic         yv,
    input  logic         yr,
    output logic         s0,
    output logic         s1
);

    logic [W-1:0] y_q, y_d;
    logic         yv_q, yv_d;
    chan_t        s_q, s_d;
    chan_t        ptr_s;

    logic [3:0]   gnt_s;
    chan_t        idx_s;
    logic         arb_en_s;
    logic         load_s;
    logic [W-1:0] sel_data_s;

    // Grants only when the holding register is free or draining this cycle;
    // nothing is granted while reset is asserted.
    assign arb_en_s = en & ~rst & (~yv_q | yr);

    rr_arb4 u_arb (
        .req_i (({v3, v2, v1, v0})),
        .ptr_i (ptr_s),
        .en_i  (arb_en_s),
        .gnt_o (gnt_s),
        .idx_o (idx_s)
    );

    assign load_s = |gnt_s;

`ifdef MUX4_FIXED_PRIO_EN
    assign ptr_s = CH3;
`else
    chan_t last_q, last_d;

    // Next pointer: follows the granted channel, frozen otherwise
    always_comb begin
        if (load_s) begin
            last_d = idx_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset to CH3 so ch0 is served first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= CH3;
        end else begin
            last_q <= last_d;
        end
    end

    assign ptr_s = last_q;
`endif

    // Data select for the granted channel
    always_comb begin
        case (idx_s)
            CH0:     sel_data_s = i0;
            CH1:     sel_data_s = i1;
            CH2:     sel_data_s = i2;
            CH3:     sel_data_s = i3;
            default: sel_data_s = '0;
        endcase
    end

    // Holding register next state: load wins over drain so a simultaneous
    // drain+load keeps yv high at full throughput.
    always_comb begin
        y_d  = y_q;
        s_d  = s_q;
        yv_d = yv_q;
        if (load_s) begin
            y_d  = sel_data_s;
            s_d  = idx_s;
            yv_d = 1'b1;
        end else if (yv_q && yr) begin
            yv_d = 1'b0;
        end else begin
            yv_d = yv_q;
        end
    end

    // Output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            yv_q <= 1'b0;
            s_q  <= CH0;
        end else begin
            y_q  <= y_d;
            yv_q <= yv_d;
            s_q  <= s_d;
        end
    end

    assign {r3, r2, r1, r0} = gnt_s;
    assign y  = y_q;
    assign yv = yv_q;
    assign s0 = s_q[1];
    assign s1 = s_q[0];

endmodule
